// File: rtl/fp_rnd_pipe_if.sv
// Shared FP32 rounding types plus the handshake/data bundle between the FMA,
// the rounding pipe and the writeback port.
package fp_rnd_pipe_pkg;

    typedef enum logic [0:0] {FP32 = 1'b0} fp_format_e;

    function automatic int unsigned fp_width(input fp_format_e fmt);
        case (fmt)
            FP32:    return 32;
            default: return 32;
        endcase
    endfunction

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

    // rs = {round bit, sticky bit} of the bits dropped below the mantissa LSB
    typedef struct packed {
        fp32_t       u_result;
        logic [1:0]  rs;
    } uround_res_t;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } roundmode_e;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    // Encoding is {s1_valid, s2_valid}
    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'b00,
        PIPE_S2    = 2'b01,
        PIPE_S1    = 2'b10,
        PIPE_FULL  = 2'b11
    } pipe_state_e;

endpackage

// Handshake: an entry moves on a rising edge where valid and ready are both
// high; valid never depends on ready, and the sender holds its data while
// valid is high and ready is low.
interface fp_rnd_pipe_if;
    logic                        valid_i;
    logic                        ready_o;
    fp_rnd_pipe_pkg::uround_res_t urnd_result_i;
    fp_rnd_pipe_pkg::roundmode_e  rnd_i;
    logic                        round_only_i;
    logic                        mul_ovf_i;
    logic                        mul_uf_i;
    logic                        mul_uround_out_i;
    logic                        valid_o;
    logic                        ready_i;
    logic [31:0]                 result_o;
    fp_rnd_pipe_pkg::status_t     flags_o;

    modport master (
        output valid_i, urnd_result_i, rnd_i, round_only_i, mul_ovf_i,
               mul_uf_i, mul_uround_out_i, ready_i,
        input  ready_o, valid_o, result_o, flags_o
    );

    modport slave (
        input  valid_i, urnd_result_i, rnd_i, round_only_i, mul_ovf_i,
               mul_uf_i, mul_uround_out_i, ready_i,
        output ready_o, valid_o, result_o, flags_o
    );
endinterface

// File: rtl/fp_rnd_pipe.sv
// Two-entry registered rounding stage behind fp_fma: capture in S1, round and
// merge FMA exception fix-ups into the S2 output register.
module fp_rnd
    import fp_rnd_pipe_pkg::*;
(
    input  uround_res_t i_urnd,
    input  roundmode_e  i_rnd,
    input  logic        i_round_only,
    input  logic        i_ovf,
    output fp32_t       o_result,
    output status_t     o_status
);
    logic        w_sign;
    logic        w_inexact;
    logic        w_inc;
    logic        w_to_inf;
    logic        w_ovf;
    logic [30:0] w_sum;

    always_comb begin
        w_sign    = i_urnd.u_result.sign;
        w_inexact = |i_urnd.rs;
        case (i_rnd)
            RNE:     w_inc = i_urnd.rs[1] & (i_urnd.rs[0] | i_urnd.u_result.mant[0]);
            RTZ:     w_inc = 1'b0;
            RDN:     w_inc = w_sign & w_inexact;
            RUP:     w_inc = ~w_sign & w_inexact;
            RMM:     w_inc = i_urnd.rs[1];
            default: w_inc = 1'b0;
        endcase
        case (i_rnd)
            RNE, RMM: w_to_inf = 1'b1;
            RDN:      w_to_inf = w_sign;
            RUP:      w_to_inf = ~w_sign;
            default:  w_to_inf = 1'b0;
        endcase
        // A mantissa carry propagates into the exponent, so one add covers both
        w_sum = {i_urnd.u_result.exp, i_urnd.u_result.mant} + {30'd0, w_inc};
        w_ovf = i_ovf | (&i_urnd.u_result.exp) | (&w_sum[30:23]);

        o_result = '0;
        o_status = '0;
        if (i_round_only) begin
            o_result = i_urnd.u_result;
        end else if (w_ovf) begin
            o_result    = w_to_inf ? {w_sign, 8'hFF, 23'd0} : {w_sign, 8'hFE, {23{1'b1}}};
            o_status.OF = 1'b1;
            o_status.NX = 1'b1;
        end else begin
            o_result    = {w_sign, w_sum};
            o_status.NX = w_inexact;
            o_status.UF = w_inexact & ~(|w_sum[30:23]);
        end
    end
endmodule

module fp_rnd_pipe
    import fp_rnd_pipe_pkg::*;
#(
    parameter fp_format_e FP_FORMAT = FP32
)
(
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          flush_i,
    fp_rnd_pipe_if.slave  bus,
    output pipe_state_e   o_dbg_state
);
    localparam int FP_WIDTH = fp_width(FP_FORMAT);

    pipe_state_e          r_state;
    pipe_state_e          w_state_nxt;
    logic                 w_s1_valid;
    logic                 w_s2_valid;
    logic                 w_s2_adv;
    logic                 w_ready;
    logic                 w_capture;

    uround_res_t          r_s1_urnd;
    roundmode_e           r_s1_rnd;
    logic                 r_s1_round_only;
    logic                 r_s1_mul_ovf;
    logic                 r_s1_mul_uf;
    logic                 r_s1_uround_out;

    fp32_t                w_rnd_result;
    status_t              w_rnd_status;
    status_t              w_flags;
    logic [FP_WIDTH-1:0]  r_result;
    status_t              r_flags;

    always_comb begin
        w_s1_valid  = r_state[1];
        w_s2_valid  = r_state[0];
        w_s2_adv    = w_s1_valid & (~w_s2_valid | bus.ready_i);
        w_ready     = ~w_s1_valid | w_s2_adv;
        w_capture   = bus.valid_i & w_ready & ~flush_i;
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = PIPE_EMPTY;
        end else begin
            w_state_nxt = pipe_state_e'({w_capture | (w_s1_valid & ~w_s2_adv),
                                         w_s2_adv | (w_s2_valid & ~bus.ready_i)});
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= PIPE_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_s1_urnd       <= '0;
            r_s1_rnd        <= RNE;
            r_s1_round_only <= 1'b0;
            r_s1_mul_ovf    <= 1'b0;
            r_s1_mul_uf     <= 1'b0;
            r_s1_uround_out <= 1'b0;
        end else if (w_capture) begin
            r_s1_urnd       <= bus.urnd_result_i;
            r_s1_rnd        <= bus.rnd_i;
            r_s1_round_only <= bus.round_only_i;
            r_s1_mul_ovf    <= bus.mul_ovf_i;
            r_s1_mul_uf     <= bus.mul_uf_i;
            r_s1_uround_out <= bus.mul_uround_out_i;
        end
    end

    fp_rnd u_fp_rnd (
        .i_urnd       (r_s1_urnd),
        .i_rnd        (r_s1_rnd),
        .i_round_only (r_s1_round_only),
        .i_ovf        (r_s1_mul_ovf),
        .o_result     (w_rnd_result),
        .o_status     (w_rnd_status)
    );

    // With mul_uf the product was already tiny before rounding, so the
    // rounder's own UF/NX view is replaced by one based on the dropped bits.
    always_comb begin
        w_flags    = w_rnd_status;
        w_flags.OF = w_rnd_status.OF | r_s1_mul_ovf;
        if (r_s1_mul_uf) begin
            w_flags.UF = ((w_rnd_result.exp == 8'd0) & (|r_s1_urnd.rs)) |
                         ((r_s1_urnd.u_result.exp == 8'd0) & (w_rnd_result.exp == 8'd1) &
                          r_s1_uround_out);
            w_flags.NX = |r_s1_urnd.rs;
        end else begin
            w_flags.UF = w_rnd_status.UF;
            w_flags.NX = w_rnd_status.NX | r_s1_mul_ovf;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_result <= '0;
            r_flags  <= '0;
        end else if (w_s2_adv & ~flush_i) begin
            r_result <= w_rnd_result;
            r_flags  <= w_flags;
        end
    end

    assign bus.ready_o  = w_ready;
    assign bus.valid_o  = r_state[0];
    assign bus.result_o = r_result;
    assign bus.flags_o  = r_flags;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_fp_rnd_pipe.sv
// Directed bench for fp_rnd_pipe: literal vectors plus a queue-based
// reference model checked against the outputs on every falling edge.
module tb_fp_rnd_pipe;
    import fp_rnd_pipe_pkg::*;

    localparam int W = 37;

    logic        clk;
    logic        reset_i;
    logic        flush_i;
    pipe_state_e dbg_state;

    fp_rnd_pipe_if bus ();

    fp_rnd_pipe #(.FP_FORMAT(FP32)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .flush_i     (flush_i),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [W-1:0] exp_q[$];
    int          acc_q[$];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model(input logic [31:0] u, input logic [1:0] rs,
                                           input logic [2:0] m, input logic ro,
                                           input logic ovf, input logic uf, input logic uro);
        logic        sgn;
        int unsigned mag;
        int unsigned rounded;
        bit          inexact, half, above, up, to_inf;
        bit          rof, ruf, rnx, of_f, uf_f, nx_f;
        logic [31:0] res;
        logic [7:0]  rexp;
        sgn     = u[31];
        mag     = {1'b0, u[30:0]};
        inexact = (rs != 2'b00);
        half    = (rs == 2'b10);
        above   = (rs == 2'b11);
        case (m)
            3'd0:    up = above || (half && (mag % 2 == 1));
            3'd2:    up = sgn && inexact;
            3'd3:    up = !sgn && inexact;
            3'd4:    up = half || above;
            default: up = 1'b0;
        endcase
        rounded = mag + (up ? 1 : 0);
        rof = 0; ruf = 0; rnx = 0;
        if (ro) begin
            res = u;
        end else if (ovf || rounded >= 32'h7F80_0000) begin
            to_inf = (m == 3'd0) || (m == 3'd4) || (m == 3'd2 && sgn) || (m == 3'd3 && !sgn);
            res    = to_inf ? {sgn, 31'h7F80_0000} : {sgn, 31'h7F7F_FFFF};
            rof    = 1; rnx = 1;
        end else begin
            res = {sgn, rounded[30:0]};
            rnx = inexact;
            ruf = inexact && (rounded < 32'h0080_0000);
        end
        rexp = res[30:23];
        of_f = rof || ovf;
        uf_f = uf ? ((rexp == 0 && inexact) || (u[30:23] == 0 && rexp == 1 && uro)) : ruf;
        nx_f = uf ? inexact : (rnx || ovf);
        return {res, 1'b0, 1'b0, of_f, uf_f, nx_f};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard update ----------------
    always @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            exp_q.delete();
            acc_q.delete();
        end else begin
            cyc++;
            if (flush_i) begin
                exp_q.delete();
                acc_q.delete();
            end else begin
                if (bus.valid_o && bus.ready_i && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                end
                if (bus.valid_i && bus.ready_o) begin
                    exp_q.push_back(model(bus.urnd_result_i.u_result, bus.urnd_result_i.rs,
                                          bus.rnd_i, bus.round_only_i, bus.mul_ovf_i,
                                          bus.mul_uf_i, bus.mul_uround_out_i));
                    acc_q.push_back(cyc);
                end
            end
        end
    end

    // ---------------- compare ----------------
    always @(negedge clk) begin
        logic exp_v;
        if (!reset_i) begin
            chk("rst_valid_o", bus.valid_o, 0);
            chk("rst_ready_o", bus.ready_o, 1);
            chk("rst_result_o", bus.result_o, 0);
            chk("rst_flags_o", bus.flags_o, 0);
        end else begin
            exp_v = (exp_q.size() > 0) && (acc_q[0] < cyc);
            chk("valid_o", bus.valid_o, exp_v);
            chk("ready_o", bus.ready_o, (exp_q.size() < 2) || bus.ready_i);
            if (bus.valid_o && exp_v) chk("out_data", {bus.result_o, bus.flags_o}, exp_q[0]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic [31:0] u, input logic [1:0] rs, input roundmode_e m,
                          input logic ovf, input logic uf, input logic uro);
        bus.urnd_result_i    = {u, rs};
        bus.rnd_i            = m;
        bus.round_only_i     = 1'b0;
        bus.mul_ovf_i        = ovf;
        bus.mul_uf_i         = uf;
        bus.mul_uround_out_i = uro;
        bus.valid_i          = 1'b1;
    endtask

    task automatic send(input logic [31:0] u, input logic [1:0] rs, input roundmode_e m,
                        input logic ovf, input logic uf, input logic uro);
        logic ok;
        int   n;
        set_in(u, rs, m, ovf, uf, uro);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = bus.ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) chk("send_timeout", 0, 1);
        bus.valid_i = 1'b0;
    endtask

    task automatic wait_out(input string name, input logic [31:0] res, input logic [4:0] flg);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid"}, bus.valid_o, 1);
        chk({name, "_result"}, bus.result_o, res);
        chk({name, "_flags"}, bus.flags_o, flg);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ent(input int k);
        return 32'h4000_0000 + k;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        reset_i              = 1'b0;
        flush_i              = 1'b0;
        bus.valid_i          = 1'b0;
        bus.ready_i          = 1'b1;
        bus.urnd_result_i    = '0;
        bus.rnd_i            = RNE;
        bus.round_only_i     = 1'b0;
        bus.mul_ovf_i        = 1'b0;
        bus.mul_uf_i         = 1'b0;
        bus.mul_uround_out_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", dbg_state, 0);
        @(posedge clk);
        #1 reset_i = 1'b1;

        // Basic with latency: invisible after the capture edge, visible after the next
        send(32'h3F80_0000, 2'b00, RNE, 0, 0, 0);
        @(negedge clk);
        chk("lat_capture_edge", bus.valid_o, 0);
        @(negedge clk);
        chk("lat_next_edge", bus.valid_o, 1);
        chk("basic_result", bus.result_o, 32'h3F80_0000);
        chk("basic_flags", bus.flags_o, 5'b00000);
        @(posedge clk);
        #1;

        send(32'h3F80_0000, 2'b11, RNE, 0, 0, 0);
        wait_out("rne_up", 32'h3F80_0001, 5'b00001);
        send(32'h3F80_0000, 2'b10, RNE, 0, 0, 0);
        wait_out("rne_tie_even", 32'h3F80_0000, 5'b00001);
        send(32'h7F7F_FFFF, 2'b11, RNE, 1, 0, 0);
        wait_out("mul_ovf", 32'h7F80_0000, 5'b00101);
        send(32'h0000_0123, 2'b01, RTZ, 0, 1, 0);
        wait_out("uf_inexact", 32'h0000_0123, 5'b00011);
        send(32'h0000_0123, 2'b00, RTZ, 0, 1, 0);
        wait_out("uf_exact", 32'h0000_0123, 5'b00000);
        send(32'h007F_FFFF, 2'b11, RNE, 0, 1, 1);
        wait_out("uf_carry_uro", 32'h0080_0000, 5'b00011);
        send(32'h007F_FFFF, 2'b11, RNE, 0, 1, 0);
        wait_out("uf_carry_nouro", 32'h0080_0000, 5'b00001);
        send(32'hBF80_0000, 2'b01, RDN, 0, 0, 0);
        wait_out("rdn_neg", 32'hBF80_0001, 5'b00001);

        // Backpressure: three stalled cycles then an uninterrupted drain
        bus.ready_i = 1'b0;
        set_in(ent(1), 2'b00, RNE, 0, 0, 0);
        @(negedge clk) chk("bp_ready_c1", bus.ready_o, 1);
        @(posedge clk); #1;
        set_in(ent(2), 2'b00, RNE, 0, 0, 0);
        @(negedge clk) chk("bp_ready_c2", bus.ready_o, 1);
        @(posedge clk); #1;
        set_in(ent(3), 2'b00, RNE, 0, 0, 0);
        @(negedge clk) chk("bp_ready_c3", bus.ready_o, 0);
        @(posedge clk); #1;
        bus.ready_i = 1'b1;
        @(negedge clk);
        chk("bp_out1_valid", bus.valid_o, 1);
        chk("bp_out1", bus.result_o, ent(1));
        @(posedge clk); #1;
        set_in(ent(4), 2'b00, RNE, 0, 0, 0);
        @(negedge clk);
        chk("bp_out2_valid", bus.valid_o, 1);
        chk("bp_out2", bus.result_o, ent(2));
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        @(negedge clk);
        chk("bp_out3_valid", bus.valid_o, 1);
        chk("bp_out3", bus.result_o, ent(3));
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_out4_valid", bus.valid_o, 1);
        chk("bp_out4", bus.result_o, ent(4));
        @(posedge clk); #1;

        // Flush while FULL
        bus.ready_i = 1'b0;
        set_in(ent(5), 2'b00, RNE, 0, 0, 0);
        @(posedge clk); #1;
        set_in(ent(6), 2'b00, RNE, 0, 0, 0);
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        flush_i     = 1'b1;
        @(negedge clk) chk("flush_pre_valid", bus.valid_o, 1);
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_valid_o", bus.valid_o, 0);
        chk("flush_ready_o", bus.ready_o, 1);
        @(posedge clk); #1;

        // Flush overrides a capture in the same cycle
        bus.ready_i = 1'b1;
        set_in(ent(7), 2'b00, RNE, 0, 0, 0);
        flush_i = 1'b1;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        flush_i     = 1'b0;
        @(negedge clk) chk("flush_cap_c1", bus.valid_o, 0);
        @(posedge clk); #1;
        @(negedge clk) chk("flush_cap_c2", bus.valid_o, 0);
        @(posedge clk); #1;
        send(32'h3F80_0000, 2'b11, RNE, 0, 0, 0);
        wait_out("post_flush", 32'h3F80_0001, 5'b00001);

        // Reset mid-stall
        bus.ready_i = 1'b0;
        set_in(ent(8), 2'b00, RNE, 0, 0, 0);
        @(posedge clk); #1;
        set_in(ent(9), 2'b00, RNE, 0, 0, 0);
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        #2 reset_i = 1'b0;
        #1;
        chk("midrst_valid_o", bus.valid_o, 0);
        chk("midrst_ready_o", bus.ready_o, 1);
        chk("midrst_result_o", bus.result_o, 0);
        chk("midrst_flags_o", bus.flags_o, 0);
        @(posedge clk); #1;
        reset_i     = 1'b1;
        bus.ready_i = 1'b1;
        send(32'h3F80_0000, 2'b00, RNE, 0, 0, 0);
        wait_out("post_reset", 32'h3F80_0000, 5'b00000);

        repeat (3) @(posedge clk);
        #1;
        chk("drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end
endmodule
